// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer, its register file, and the ROM /
// assembler tables: instruction field positions, opcodes, FSM states.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int OP_W     = 3;
    localparam int REG_AW   = 3;
    localparam int INSTR_W  = OP_W + 2 * REG_AW;

    // Instruction layout: [8:6] opcode, [5:3] rx (destination), [2:0] ry (source)
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_LOAD = 3'b000;
    localparam opcode_t OP_MOV  = 3'b001;
    localparam opcode_t OP_ADD  = 3'b010;
    localparam opcode_t OP_XOR  = 3'b011;
    localparam opcode_t OP_HALT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Opcodes that write R[rx] in EXEC
    function automatic logic op_writes(opcode_t op);
        return (op == OP_LOAD) || (op == OP_MOV) || (op == OP_ADD) || (op == OP_XOR);
    endfunction

    // Opcodes above halt are unassigned
    function automatic logic op_illegal(opcode_t op);
        return op > OP_HALT;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x16 register file: one synchronous write port, a dual-address operand
// read port and an independent debug read port, all reads combinational.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset clears every register; otherwise one write per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-write value in the cycle a write is pending
    assign rd_a     = regs[ra];
    assign rd_b     = regs[rb];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute control stage behind the program ROM. Each instruction takes
// FETCH, EXEC, ADVANCE, SETTLE (4 cycles); halt parks the FSM in HALT.
// Build option: ILLEGAL_OP_TRAP_EN makes opcodes 101..111 trap to HALT with
// a sticky err flag; without it they execute as NOPs and err is tied low.
//
// ROM handshake: step is a registered single-cycle pulse driven in ADVANCE.
// The ROM advances its address on that pulse and must present the new
// instruction/data_var by the end of SETTLE; the sequencer samples them in
// FETCH only. There is no back-pressure: the ROM is assumed always ready.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [DATA_W-1:0]  data_var,
    output logic               step,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wr_en,
    output logic [DATA_W-1:0]  wr_data,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output state_t             dbg_state
);

    state_t             state_q;
    state_t             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [DATA_W-1:0]  dr_q;
    logic               step_d;
    logic               busy_d;
    logic               done_d;
    logic               wr_en_d;
    logic               trap_hit;
    logic [DATA_W-1:0]  rx_val;
    logic [DATA_W-1:0]  ry_val;
    logic [DATA_W-1:0]  alu_res;

    opcode_t            op_ir;
    logic [REG_AW-1:0]  rx_ir;
    logic [REG_AW-1:0]  ry_ir;

    assign op_ir     = ir_q[OP_MSB:OP_LSB];
    assign rx_ir     = ir_q[RX_MSB:RX_LSB];
    assign ry_ir     = ir_q[RY_MSB:RY_LSB];
    assign dbg_state = state_q;

    // State, instruction/data latches and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            dr_q    <= '0;
            step    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
        end else begin
            state_q <= state_d;
            step    <= step_d;
            busy    <= busy_d;
            done    <= done_d;
            wr_en   <= wr_en_d;
            if (state_q == ST_FETCH) begin
                ir_q <= instruction;
                dr_q <= data_var;
            end
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign trap_hit = op_illegal(op_ir);

    // Sticky trap flag, set on leaving EXEC with an illegal opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state_q == ST_EXEC) && trap_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign trap_hit = 1'b0;
    assign err      = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_EXEC;
            ST_EXEC: begin
                if ((op_ir == OP_HALT) || trap_hit) state_d = ST_HALT;
                else                                state_d = ST_ADVANCE;
            end
            ST_ADVANCE: state_d = ST_SETTLE;
            ST_SETTLE:  state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the outputs register glitch-free;
    // EXEC is only entered from FETCH, where the opcode is still on the bus
    always_comb begin
        step_d  = (state_d == ST_ADVANCE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_HALT);
        done_d  = (state_d == ST_HALT);
        wr_en_d = (state_d == ST_EXEC) && op_writes(instruction[OP_MSB:OP_LSB]);
    end

    // ALU on pre-write operand values; add wraps modulo 2^16
    always_comb begin
        case (op_ir)
            OP_LOAD: alu_res = dr_q;
            OP_MOV:  alu_res = ry_val;
            OP_ADD:  alu_res = rx_val + ry_val;
            OP_XOR:  alu_res = rx_val ^ ry_val;
            default: alu_res = '0;
        endcase
    end

    assign wr_data = wr_en ? alu_res : '0;

    cpu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .wa       (rx_ir),
        .wd       (alu_res),
        .ra       (rx_ir),
        .rb       (ry_ir),
        .dbg_sel  (dbg_sel),
        .rd_a     (rx_val),
        .rd_b     (ry_val),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a behavioural ROM that advances its
// address on each clock edge where step is high.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  instruction;
  logic [15:0] data_var;
  logic        step;
  logic        busy;
  logic        done;
  logic        err;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;
  state_t      dbg_state;

  logic [8:0]  rom_ins [16];
  logic [15:0] rom_dat [16];
  logic [3:0]  rom_addr;
  logic        rom_clr;

  int n_checks;
  int n_errors;

  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];

  cpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instruction (instruction),
    .data_var    (data_var),
    .step        (step),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .dbg_state   (dbg_state)
  );

  // clock / ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_clr) rom_addr <= '0;
    else if (step) rom_addr <= rom_addr + 4'd1;
  end

  assign instruction = rom_ins[rom_addr];
  assign data_var    = rom_dat[rom_addr];

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry};
  endfunction

  // driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 16; i++) begin
      rom_ins[i] = enc(3'b100, 3'd0, 3'd0);
      rom_dat[i] = 16'h0000;
    end
  endtask

  task automatic set_rom(input int idx, input logic [8:0] ins, input logic [15:0] dat);
    rom_ins[idx] = ins;
    rom_dat[idx] = dat;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rom_clr = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rom_clr = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_reg(input int idx, output logic [15:0] val);
    dbg_sel = idx[2:0];
    #1;
    val = dbg_data;
  endtask

  // Runs until done, sampling at negedge; records writes into got_q
  task automatic run_prog(input int max_cycles, output int steps, output int busy_cyc,
                          output int wr_bad, output int gap_bad, output bit timed_out);
    int last_step;
    steps = 0; busy_cyc = 0; wr_bad = 0; gap_bad = 0; timed_out = 1'b1;
    last_step = -1;
    got_q.delete();
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (step) begin
        if (last_step >= 0 && (cyc - last_step) != 4) gap_bad++;
        last_step = cyc;
        steps++;
      end
      if (busy) busy_cyc++;
      if (wr_en && dbg_state != ST_EXEC) wr_bad++;
      if (wr_en) got_q.push_back(wr_data);
      @(negedge clk);
    end
  endtask

  task automatic load_standard();
    clear_rom();
    set_rom(0,  enc(3'b000, 3'd0, 3'd0), 16'd1);
    set_rom(1,  enc(3'b000, 3'd1, 3'd0), 16'd2);
    set_rom(2,  enc(3'b000, 3'd2, 3'd0), 16'd3);
    set_rom(3,  enc(3'b000, 3'd3, 3'd0), 16'd4);
    set_rom(4,  enc(3'b000, 3'd0, 3'd0), 16'd5);
    set_rom(5,  enc(3'b011, 3'd1, 3'd3), 16'd0);
    set_rom(6,  enc(3'b001, 3'd2, 3'd1), 16'd0);
    set_rom(7,  enc(3'b010, 3'd2, 3'd1), 16'd0);
    set_rom(8,  enc(3'b010, 3'd3, 3'd1), 16'd0);
    set_rom(9,  enc(3'b011, 3'd0, 3'd3), 16'd0);
    set_rom(10, enc(3'b100, 3'd0, 3'd0), 16'd0);
  endtask

  // tests
  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    n_checks++;
    if ({step, busy, done, err, wr_en} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags got=%b exp=00000", {step, busy, done, err, wr_en});
    end
    n_checks++;
    if (wr_data !== 16'h0) begin n_errors++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      n_checks++;
      if (v !== 16'h0) begin n_errors++; $display("FAIL reset_r%0d got=%h exp=0000", i, v); end
    end
  endtask

  task automatic test_standard();
    int steps, busy_cyc, wr_bad, gap_bad;
    bit to;
    logic [15:0] v;
    logic [15:0] exp_r [4];
    exp_r[0] = 16'd15; exp_r[1] = 16'd6; exp_r[2] = 16'd12; exp_r[3] = 16'd10;
    exp_q.delete();
    exp_q.push_back(16'd1); exp_q.push_back(16'd2); exp_q.push_back(16'd3);
    exp_q.push_back(16'd4); exp_q.push_back(16'd5); exp_q.push_back(16'd6);
    exp_q.push_back(16'd6); exp_q.push_back(16'd12); exp_q.push_back(16'd10);
    exp_q.push_back(16'd15);
    load_standard();
    do_reset();
    kick();
    run_prog(200, steps, busy_cyc, wr_bad, gap_bad, to);
    n_checks++;
    if (to) begin n_errors++; $display("FAIL std_timeout got=no_done exp=done within 200 cycles"); end
    n_checks++;
    if (steps != 10) begin n_errors++; $display("FAIL std_steps got=%0d exp=10", steps); end
    // 10 instructions x 4 cycles, plus FETCH and EXEC of the halt word
    n_checks++;
    if (busy_cyc != 42) begin n_errors++; $display("FAIL std_busy_cycles got=%0d exp=42", busy_cyc); end
    n_checks++;
    if (wr_bad != 0) begin n_errors++; $display("FAIL std_wr_en_outside_exec got=%0d exp=0", wr_bad); end
    n_checks++;
    if (gap_bad != 0) begin n_errors++; $display("FAIL std_step_spacing got=%0d exp=0", gap_bad); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL std_write_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL std_wr_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      n_checks++;
      if (v !== exp_r[i]) begin n_errors++; $display("FAIL std_r%0d got=%0d exp=%0d", i, v, exp_r[i]); end
    end
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL std_err got=%b exp=0", err); end
    // HALT ignores start and never steps or writes
    start = 1'b1;
    steps = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (step || wr_en || dbg_state != ST_HALT || !done) steps++;
    end
    start = 1'b0;
    n_checks++;
    if (steps != 0) begin n_errors++; $display("FAIL halt_hold bad_cycles=%0d exp=0", steps); end
  endtask

  task automatic test_add_overflow();
    int steps, busy_cyc, wr_bad, gap_bad;
    bit to;
    logic [15:0] v;
    clear_rom();
    set_rom(0, enc(3'b000, 3'd4, 3'd0), 16'hFFFF);
    set_rom(1, enc(3'b000, 3'd5, 3'd0), 16'h0003);
    set_rom(2, enc(3'b010, 3'd4, 3'd5), 16'h0000);
    do_reset();
    kick();
    run_prog(100, steps, busy_cyc, wr_bad, gap_bad, to);
    n_checks++;
    if (to || steps != 3) begin n_errors++; $display("FAIL ovf_run got steps=%0d timeout=%0b exp steps=3 timeout=0", steps, to); end
    read_reg(4, v);
    n_checks++;
    if (v !== 16'h0002) begin n_errors++; $display("FAIL ovf_r4 got=%h exp=0002", v); end
    read_reg(5, v);
    n_checks++;
    if (v !== 16'h0003) begin n_errors++; $display("FAIL ovf_r5 got=%h exp=0003", v); end
  endtask

  task automatic test_self_operand();
    int steps, busy_cyc, wr_bad, gap_bad;
    bit to;
    logic [15:0] v;
    clear_rom();
    set_rom(0, enc(3'b000, 3'd6, 3'd0), 16'h00A5);
    set_rom(1, enc(3'b011, 3'd6, 3'd6), 16'h0000);
    set_rom(2, enc(3'b000, 3'd7, 3'd0), 16'h4000);
    set_rom(3, enc(3'b010, 3'd7, 3'd7), 16'h0000);
    set_rom(4, enc(3'b001, 3'd7, 3'd7), 16'h0000);
    do_reset();
    kick();
    run_prog(100, steps, busy_cyc, wr_bad, gap_bad, to);
    n_checks++;
    if (to || steps != 5) begin n_errors++; $display("FAIL self_run got steps=%0d timeout=%0b exp steps=5 timeout=0", steps, to); end
    read_reg(6, v);
    n_checks++;
    if (v !== 16'h0000) begin n_errors++; $display("FAIL self_xor_r6 got=%h exp=0000", v); end
    read_reg(7, v);
    n_checks++;
    if (v !== 16'h8000) begin n_errors++; $display("FAIL self_add_r7 got=%h exp=8000", v); end
  endtask

  task automatic test_reset_mid();
    int execs, bad, steps, busy_cyc, wr_bad, gap_bad;
    bit to;
    logic [15:0] v;
    load_standard();
    do_reset();
    kick();
    execs = 0;
    for (int cyc = 0; cyc < 40 && execs < 3; cyc++) begin
      if (dbg_state == ST_EXEC) execs++;
      if (execs < 3) @(negedge clk);
    end
    n_checks++;
    if (execs != 3) begin n_errors++; $display("FAIL mid_reach_exec3 got=%0d exp=3", execs); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (dbg_state !== ST_IDLE || step !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL mid_after_rst got state=%0d step=%b busy=%b exp state=0 step=0 busy=0", dbg_state, step, busy);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      if (v !== 16'h0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL mid_regs_cleared nonzero=%0d exp=0", bad); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dbg_state != ST_IDLE || step || wr_en) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL mid_wait_start bad_cycles=%0d exp=0", bad); end
    // restart from address 0 after start
    rom_clr = 1'b1;
    @(negedge clk);
    rom_clr = 1'b0;
    kick();
    run_prog(200, steps, busy_cyc, wr_bad, gap_bad, to);
    read_reg(0, v);
    n_checks++;
    if (to || steps != 10 || v !== 16'd15) begin
      n_errors++; $display("FAIL mid_restart got steps=%0d r0=%0d timeout=%0b exp steps=10 r0=15 timeout=0", steps, v, to);
    end
  endtask

  task automatic test_illegal();
    int steps, busy_cyc, wr_bad, gap_bad;
    bit to;
    logic [15:0] v1, v2;
    clear_rom();
    set_rom(0, enc(3'b000, 3'd1, 3'd0), 16'd7);
    set_rom(1, enc(3'b101, 3'd1, 3'd2), 16'hBEEF);
    set_rom(2, enc(3'b000, 3'd2, 3'd0), 16'd9);
    do_reset();
    kick();
    run_prog(100, steps, busy_cyc, wr_bad, gap_bad, to);
    read_reg(1, v1);
    read_reg(2, v2);
    n_checks++;
    if (to) begin n_errors++; $display("FAIL ill_timeout got=no_done exp=done"); end
    n_checks++;
    if (v1 !== 16'd7) begin n_errors++; $display("FAIL ill_r1 got=%0d exp=7", v1); end
`ifdef ILLEGAL_OP_TRAP_EN
    n_checks++;
    if (steps != 1) begin n_errors++; $display("FAIL ill_trap_steps got=%0d exp=1", steps); end
    n_checks++;
    if (err !== 1'b1 || done !== 1'b1) begin n_errors++; $display("FAIL ill_trap_flags got err=%b done=%b exp err=1 done=1", err, done); end
    n_checks++;
    if (v2 !== 16'd0) begin n_errors++; $display("FAIL ill_trap_r2 got=%0d exp=0", v2); end
`else
    n_checks++;
    if (steps != 3) begin n_errors++; $display("FAIL ill_nop_steps got=%0d exp=3", steps); end
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL ill_nop_err got=%b exp=0", err); end
    n_checks++;
    if (v2 !== 16'd9) begin n_errors++; $display("FAIL ill_nop_r2 got=%0d exp=9", v2); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    rom_clr = 1'b1;
    start = 1'b0;
    dbg_sel = 3'd0;
    clear_rom();
    test_reset();
    test_standard();
    test_add_overflow();
    test_self_operand();
    test_reset_mid();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
